// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters; drives the fetch PC-mux select and flush.
// Optional macro BP_STATS_EN adds branch / mispredict statistics counters.
module branch_predictor_btb #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] f_pc,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_pred_target,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    output logic [1:0]       pc_select,
    output logic             flush
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int TAG_W   = WIDTH - 2 - INDEX_BITS;
    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic                  valid_r  [ENTRIES];
    logic [TAG_W-1:0]      tag_r    [ENTRIES];
    logic [WIDTH-1:0]      target_r [ENTRIES];
    logic [1:0]            ctr_r    [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx_s;
    logic [TAG_W-1:0]      f_tag_s;
    logic [INDEX_BITS-1:0] ex_idx_s;
    logic [TAG_W-1:0]      ex_tag_s;
    logic                  f_hit_s;
    logic                  ex_hit_s;
    logic                  res_s;
    logic                  mispredict_s;
    logic                  unused_pc_bits_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign f_idx_s          = f_pc[INDEX_BITS+1:2];
    assign f_tag_s          = f_pc[WIDTH-1:INDEX_BITS+2];
    assign ex_idx_s         = ex_pc[INDEX_BITS+1:2];
    assign ex_tag_s         = ex_pc[WIDTH-1:INDEX_BITS+2];
    assign unused_pc_bits_s = ^{f_pc[1:0], ex_pc[1:0]};

    // Lookup, misprediction detection and PC-mux select; reset forces a quiet fetch.
    always_comb begin
        f_hit_s      = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
        ex_hit_s     = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
        res_s        = ex_valid && ex_is_branch;
        mispredict_s = res_s && ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
        pred_taken   = 1'b0;
        pred_target  = {WIDTH{1'b0}};
        pc_select    = 2'b00;
        flush        = 1'b0;
        if (reset) begin
            pred_taken  = 1'b0;
            pred_target = {WIDTH{1'b0}};
            pc_select   = 2'b00;
            flush       = 1'b0;
        end else begin
            pred_taken  = f_hit_s && ctr_r[f_idx_s][1];
            pred_target = f_hit_s ? target_r[f_idx_s] : {WIDTH{1'b0}};
            flush       = mispredict_s;
            // Execute-stage recovery always wins over the fetch prediction.
            if (mispredict_s && ex_taken) begin
                pc_select = 2'b10;
            end else if (mispredict_s) begin
                pc_select = 2'b11;
            end else if (pred_taken) begin
                pc_select = 2'b01;
            end else begin
                pc_select = 2'b00;
            end
        end
    end

    // Table update from resolved branches; reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {WIDTH{1'b0}};
                ctr_r[i]    <= 2'b01;
            end
        end else if (res_s) begin
            if (ex_hit_s) begin
                if (ex_taken) begin
                    ctr_r[ex_idx_s]    <= sat_inc(ctr_r[ex_idx_s]);
                    target_r[ex_idx_s] <= ex_target;
                end else begin
                    ctr_r[ex_idx_s]    <= sat_dec(ctr_r[ex_idx_s]);
                end
            end else if (ex_taken) begin
                // Taken miss replaces whatever alias occupied this index.
                valid_r[ex_idx_s]  <= 1'b1;
                tag_r[ex_idx_s]    <= ex_tag_s;
                target_r[ex_idx_s] <= ex_target;
                ctr_r[ex_idx_s]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    // Free-running statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (res_s) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict_s) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: a behavioural table model predicts each cycle's outputs.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pc_select;
    logic        flush;

    branch_predictor_btb #(.WIDTH(32), .INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .pc_select(pc_select), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pt;
        logic [31:0] tg;
        logic [1:0]  sel;
        logic        fl;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_ctr   [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out(input logic rst, input logic [31:0] fpc, input logic v,
                                       input logic br, input logic tk, input logic [31:0] tgt,
                                       input logic ptk, input logic [31:0] ptgt);
        exp_t e;
        int   i;
        logic hit, misp;
        e = '0;
        if (!rst) begin
            i    = int'(fpc[5:2]);
            hit  = m_valid[i] && (m_tag[i] == fpc[31:6]);
            e.pt = hit && m_ctr[i][1];
            e.tg = hit ? m_tgt[i] : 32'h0;
            misp = v && br && ((tk != ptk) || (tk && ptk && (tgt != ptgt)));
            e.fl = misp;
            if (misp && tk)      e.sel = 2'b10;
            else if (misp)       e.sel = 2'b11;
            else if (e.pt)       e.sel = 2'b01;
            else                 e.sel = 2'b00;
        end
        return e;
    endfunction

    task automatic model_update(input logic rst, input logic v, input logic br, input logic tk,
                                input logic [31:0] pc, input logic [31:0] tgt);
        int   i;
        logic hit;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0; m_tag[k] = 26'h0; m_tgt[k] = 32'h0; m_ctr[k] = 2'b01;
            end
        end else if (v && br) begin
            i   = int'(pc[5:2]);
            hit = m_valid[i] && (m_tag[i] == pc[31:6]);
            if (hit && tk) begin
                m_ctr[i] = (m_ctr[i] == 2'b11) ? 2'b11 : m_ctr[i] + 2'b01;
                m_tgt[i] = tgt;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 2'b00) ? 2'b00 : m_ctr[i] - 2'b01;
            end else if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = pc[31:6]; m_tgt[i] = tgt; m_ctr[i] = 2'b10;
            end
        end
    endtask

    // One cycle: drive on the falling edge, compare mid-low-phase, advance the model on the rising edge.
    task automatic vec(input string name, input logic rst, input logic [31:0] fpc,
                       input logic v, input logic br, input logic tk, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        exp_t e;
        @(negedge clk);
        reset = rst; f_pc = fpc; ex_valid = v; ex_is_branch = br; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        sb_q.push_back(model_out(rst, fpc, v, br, tk, tgt, ptk, ptgt));
        #1;
        e = sb_q.pop_front();
        check({name, ".pred_taken"},  {31'h0, pred_taken}, {31'h0, e.pt});
        check({name, ".pred_target"}, pred_target,         e.tg);
        check({name, ".pc_select"},   {30'h0, pc_select},  {30'h0, e.sel});
        check({name, ".flush"},       {31'h0, flush},      {31'h0, e.fl});
        @(posedge clk);
        model_update(rst, v, br, tk, pc, tgt);
    endtask

    task automatic look(input string name, input logic [31:0] fpc);
        vec(name, 1'b0, fpc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    logic [31:0] pcs [4];

    initial begin
        pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h180; pcs[3] = 32'h1C4;
        reset = 1'b1; f_pc = 32'h0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        model_update(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        vec("reset0", 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        vec("reset1", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        look("idle_miss", 32'h100);
        // First taken resolve: mispredict then allocation.
        vec("alloc", 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        look("hit_after_alloc", 32'h100);
        vec("tk_pred1_a", 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
        vec("tk_pred1_b", 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
        vec("nt_flush_a", 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
        look("still_taken", 32'h100);
        vec("nt_flush_b", 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
        look("now_not_taken", 32'h100);
        vec("retrain", 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        look("alias_miss", 32'h140);
        vec("alias_alloc", 1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 32'h140, 32'h300, 1'b0, 32'h0);
        look("old_evicted", 32'h100);
        look("alias_hit", 32'h140);
        // Same-cycle update and lookup; target mismatch also flushes.
        vec("same_cycle", 1'b0, 32'h140, 1'b1, 1'b1, 1'b1, 32'h140, 32'h380, 1'b1, 32'h300);
        look("new_target", 32'h140);
        vec("gated_valid", 1'b0, 32'h104, 1'b0, 1'b1, 1'b1, 32'h180, 32'h999, 1'b0, 32'h0);
        vec("gated_branch", 1'b0, 32'h104, 1'b1, 1'b0, 1'b1, 32'h180, 32'h999, 1'b0, 32'h0);
        look("gated_miss", 32'h180);
        vec("nt_miss", 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h1C4, 32'h444, 1'b0, 32'h0);
        look("nt_no_alloc", 32'h1C4);

        for (int n = 0; n < 40; n++) begin
            vec("rand", 1'b0, pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)],
                32'h1000 + 32'($urandom_range(0, 3) * 4), 1'($urandom_range(0, 1)),
                32'h1000 + 32'($urandom_range(0, 3) * 4));
        end

        vec("prime", 1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        vec("mid_reset", 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h140, 32'h500, 1'b0, 32'h0);
        look("post_reset_100", 32'h100);
        look("post_reset_140", 32'h140);
        look("post_reset_1c4", 32'h1C4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
